// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned INIT_ZERO  = 0;
  localparam int unsigned INIT_INDEX = 1;

  // Address width for a file of n registers (at least one bit).
  function automatic int unsigned addr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by allocation, cleared by writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [AW-1:0]         set_addr,
  input  logic                  clr_en,
  input  logic [AW-1:0]         clr_addr,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD-1:0]      rs_pending
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Next pending vector: clear first so a same-cycle allocation wins; reg 0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending register, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Per-port lookup; a write in this cycle resolves the hazard through the bypass.
  always_comb begin
    rs_pending = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rs_pending[i] = pending_q[rs_addr[i*AW +: AW]] &&
                      !(clr_en && (clr_addr == rs_addr[i*AW +: AW]));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, write bypass, hazard scoreboard and init sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN      = 64,
  parameter  int unsigned NREGS     = 32,
  parameter  int unsigned NREAD     = 2,
  parameter  int unsigned INIT_MODE = INIT_ZERO,
  localparam int unsigned AW        = addr_width(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     rs_addr,
  output logic [NREAD*XLEN-1:0]   rs_data,
  output logic [NREAD-1:0]        rs_pending,
  input  logic                    wr_en,
  input  logic [AW-1:0]           rd_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_addr,
  output logic                    ready
);

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            run;
  logic            wr_ok;
  logic            alloc_ok;
  logic [XLEN-1:0] init_val;
  logic [NREAD-1:0] sb_pending;

  assign run      = (state_q == RUN);
  assign wr_ok    = run && wr_en && (rd_addr != '0);
  assign alloc_ok = run && alloc_en && (alloc_addr != '0);
  assign init_val = (INIT_MODE == INIT_INDEX) ? XLEN'(cnt_q) : '0;
  assign ready    = ready_q;

  // Init sweep FSM: walk cnt over every register, then enter RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREGS - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ;
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage: sweep loads during INIT, write port in RUN; reset itself leaves contents alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT)  regs_q[cnt_q]   <= init_val;
      else if (wr_ok)       regs_q[rd_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (alloc_ok),
    .set_addr   (alloc_addr),
    .clr_en     (wr_ok),
    .clr_addr   (rd_addr),
    .rs_addr    (rs_addr),
    .rs_pending (sb_pending)
  );

  // Read muxes with same-cycle bypass; everything reads as zero until the sweep completes.
  always_comb begin
    rs_data    = '0;
    rs_pending = sb_pending & {NREAD{run}};
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (run && (rs_addr[i*AW +: AW] != '0)) begin
        if (wr_ok && (rd_addr == rs_addr[i*AW +: AW]))
          rs_data[i*XLEN +: XLEN] = wr_data;
        else
          rs_data[i*XLEN +: XLEN] = regs_q[rs_addr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: two instances (zero and index init) share stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 4;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  wr_en;
  logic [AW-1:0]         rd_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  alloc_en;
  logic [AW-1:0]         alloc_addr;
  logic [NREAD*AW-1:0]   rs_addr;

  logic [NREAD*XLEN-1:0] rs_data_z, rs_data_i;
  logic [NREAD-1:0]      pend_z, pend_i;
  logic                  ready_z, ready_i;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .INIT_MODE(INIT_ZERO)) dut_z (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_z), .rs_pending(pend_z),
    .wr_en(wr_en), .rd_addr(rd_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .ready(ready_z)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .INIT_MODE(INIT_INDEX)) dut_i (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_i), .rs_pending(pend_i),
    .wr_en(wr_en), .rd_addr(rd_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .ready(ready_i)
  );

  typedef struct {
    logic [NREAD*XLEN-1:0] data_z;
    logic [NREAD*XLEN-1:0] data_i;
    logic [NREAD-1:0]      pend;
    logic                  rdy;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit              m_known = 1'b0;
  bit              m_ready = 1'b0;
  int              m_cnt   = 0;
  logic [XLEN-1:0] mem_z [NREGS];
  logic [XLEN-1:0] mem_i [NREGS];
  bit              m_pend [NREGS];

  function automatic exp_t predict();
    exp_t e;
    e.data_z = '0;
    e.data_i = '0;
    e.pend   = '0;
    e.rdy    = m_ready;
    if (m_ready) begin
      for (int p = 0; p < NREAD; p++) begin
        int  a;
        bit  byp;
        a   = int'(rs_addr[p*AW +: AW]);
        byp = wr_en && (int'(rd_addr) == a);
        if (a != 0) begin
          e.data_z[p*XLEN +: XLEN] = byp ? wr_data : mem_z[a];
          e.data_i[p*XLEN +: XLEN] = byp ? wr_data : mem_i[a];
          e.pend[p] = m_pend[a] && !byp;
        end
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
    end else if (!m_ready) begin
      mem_z[m_cnt] = '0;
      mem_i[m_cnt] = XLEN'(m_cnt);
      m_cnt++;
      if (m_cnt == NREGS) m_ready = 1'b1;
    end else begin
      if (wr_en && rd_addr != 0) begin
        mem_z[rd_addr]  = wr_data;
        mem_i[rd_addr]  = wr_data;
        m_pend[rd_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
    end
  endtask

  // One clock of stimulus: drive, queue expectation, advance model at the edge.
  task automatic cycle(input logic rst, input logic we, input int rd, input logic [XLEN-1:0] wd,
                       input logic ae, input int aa, input logic [NREAD*AW-1:0] ra);
    reset      = rst;
    wr_en      = we;
    rd_addr    = AW'(rd);
    wr_data    = wd;
    alloc_en   = ae;
    alloc_addr = AW'(aa);
    rs_addr    = ra;
    if (m_known) exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    m_known = 1'b1;
    #1;
  endtask

  function automatic logic [NREAD*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic idle_read(input logic [NREAD*AW-1:0] ra);
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, ra);
  endtask

  task automatic rand_cycle(input logic rst);
    int rd, aa;
    logic [NREAD*AW-1:0] ra;
    rd = int'($urandom_range(0, NREGS - 1));
    aa = ($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, NREGS - 1));
    for (int p = 0; p < NREAD; p++)
      ra[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(rd) : AW'($urandom_range(0, NREGS - 1));
    cycle(rst, 1'($urandom_range(0, 1)), rd, {$urandom, $urandom},
          1'($urandom_range(0, 2) == 0), aa, ra);
  endtask

  task automatic chk(input string nm, input logic [NREAD*XLEN-1:0] act, input logic [NREAD*XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ready_z",   (NREAD*XLEN)'(ready_z), (NREAD*XLEN)'(e.rdy));
      chk("ready_i",   (NREAD*XLEN)'(ready_i), (NREAD*XLEN)'(e.rdy));
      chk("data_zero", rs_data_z, e.data_z);
      chk("data_idx",  rs_data_i, e.data_i);
      chk("pend_zero", (NREAD*XLEN)'(pend_z), (NREAD*XLEN)'(e.pend));
      chk("pend_idx",  (NREAD*XLEN)'(pend_i), (NREAD*XLEN)'(e.pend));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rs_addr = '0;

    // Reset, then the full sweep with ignored write/alloc noise.
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);
    cycle(1'b1, 1'b1, 4, 64'h55, 1'b1, 4, pack4(4, 4, 0, 1));
    for (int n = 0; n < NREGS; n++) rand_cycle(1'b0);

    // Sweep contents.
    idle_read(pack4(12, 13, 14, 0));
    idle_read(pack4(31, 1, 2, 3));

    // Bypass, then registered value; writes to reg 0 are dropped.
    cycle(1'b0, 1'b1, 5, 64'hDEAD, 1'b0, 0, pack4(5, 6, 5, 0));
    idle_read(pack4(5, 5, 0, 6));
    cycle(1'b0, 1'b1, 0, 64'h1234, 1'b0, 0, pack4(0, 0, 0, 0));
    idle_read(pack4(0, 0, 0, 0));

    // Scoreboard: allocate, resolve by write, then same-cycle alloc + write.
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 7, pack4(7, 7, 7, 7));
    idle_read(pack4(7, 7, 0, 8));
    cycle(1'b0, 1'b1, 7, 64'hA7, 1'b0, 0, pack4(7, 7, 7, 7));
    idle_read(pack4(7, 7, 7, 7));
    cycle(1'b0, 1'b1, 7, 64'hB7, 1'b1, 7, pack4(7, 7, 7, 7));
    idle_read(pack4(7, 7, 7, 7));
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 0, pack4(0, 7, 0, 7));
    idle_read(pack4(0, 7, 0, 7));

    // Four ports: distinct addresses, then a shared one.
    idle_read(pack4(5, 7, 12, 20));
    idle_read(pack4(12, 12, 12, 12));

    // Randomised traffic.
    for (int n = 0; n < 300; n++) rand_cycle(1'b0);

    // Reset mid-operation and mid-sweep.
    cycle(1'b0, 1'b1, 3, 64'hFF, 1'b1, 9, pack4(3, 9, 3, 9));
    idle_read(pack4(3, 9, 3, 9));
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, pack4(3, 9, 3, 9));
    for (int n = 0; n < 10; n++) rand_cycle(1'b0);
    cycle(1'b1, 1'b1, 3, 64'hEE, 1'b1, 3, pack4(3, 9, 3, 9));
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, pack4(3, 9, 3, 9));
    for (int n = 0; n < NREGS; n++) rand_cycle(1'b0);
    idle_read(pack4(3, 9, 1, 31));

    for (int n = 0; n < 100; n++) rand_cycle(1'b0);
    idle_read(pack4(1, 2, 3, 4));

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the datapath. It replaces the fixed 2-read/1-write, 32×64 file, and adds:
- a hardwired zero register;
- write-to-read bypass;
- a pending-write scoreboard for hazard detection;
- a sequenced post-reset initialisation sweep that loads registers with zero or index values.

It sits between decode (read addresses, allocation) and writeback (write port).

## Interface
Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of registers (power of two, ≥4); AW = log2(NREGS)
- NREAD, 2, number of read ports (1–4)
- INIT_MODE, 0, value loaded by the init sweep: 0 → all zero; 1 → register i = i (zero-extended to XLEN)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- rs_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rs_data  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rs_pending  out  NREAD  port i's source has an outstanding producer
- wr_en  in  1  write enable
- rd_addr  in  AW  write address
- wr_data  in  XLEN  write data
- alloc_en  in  1  mark alloc_addr as having an in-flight producer
- alloc_addr  in  AW  register being allocated
- ready  out  1  init sweep complete; writes and allocations are accepted

## Operation
- Reset behaviour:
  - The reset value of every output is zero.
  - Reset forces state INIT with counter cnt=0, clears all pending bits, and drives ready=0.
  - Register contents are not cleared directly by reset; the sweep loads them.
- INIT state:
  - Each cycle writes reg[cnt] = (INIT_MODE ? cnt : 0), then cnt++.
  - The cycle that writes cnt = NREGS-1 transitions to RUN.
  - While in INIT: wr_en and alloc_en are ignored, rs_data = 0, and rs_pending = 0.
- RUN state:
  - ready = 1.
  - Reset returns the block to INIT, cnt = 0, at any time, including mid-sweep.
- Register 0:
  - Writes to reg 0 are dropped, and allocations of reg 0 are dropped.
  - Reads of address 0 return 0 and rs_pending = 0.
- Reads are combinational, one path per port:
  - If wr_en && rd_addr == rs_addr[i] && rs_addr[i] != 0, rs_data[i] = wr_data (bypass).
  - Otherwise rs_data[i] = reg[rs_addr[i]].
  - Ports are independent; any ports may share an address.
- Scoreboard, updated on the clock edge:
  - alloc_en sets pending[alloc_addr].
  - wr_en clears pending[rd_addr].
  - If alloc_en and wr_en target the same address in the same cycle, the set wins (a new producer is issued).
- rs_pending[i] = pending[rs_addr[i]] && !(wr_en && rd_addr == rs_addr[i]). A same-cycle write resolves the hazard through the bypass.
- The write port has no protection. A write to a non-pending register is legal and simply updates it.

## Timing
- Read latency: 0 cycles, combinational from rs_addr, wr_en, rd_addr and wr_data.
- Write latency: 1 cycle. The register is updated at the edge; the bypass covers the same cycle.
- If reset is sampled high at edge k and low from k+1 onward:
  - Edges k+1 … k+NREGS perform the sweep.
  - ready rises after edge k+NREGS.
- While reset is held high, the block stays at INIT with cnt = 0 and no sweep writes occur.
- An allocation takes effect the cycle after alloc_en. A read in the same cycle does not see the new pending bit.

## Structure
- Package regfile_pkg:
  - state enum {INIT, RUN};
  - INIT_ZERO = 0 and INIT_INDEX = 1 constants;
  - the AW computation function.
- Sub-module regfile_scoreboard:
  - contains the NREGS-bit pending vector with set/clear priority and the reg-0 mask;
  - exposes a per-port pending lookup with the bypass qualifier.
- The top level holds the storage array, the init FSM and counter, and the read muxes and bypass.

## Test plan
- Reset then wait, NREGS=32, INIT_MODE=1:
  - ready = 0 for 32 cycles after reset drops, then 1;
  - afterwards reads of regs 12, 13 and 14 return 12, 13 and 14.
- Write, bypass and x0:
  - wr_en, rd=5, data=0xDEAD with rs_addr[0]=5 → rs_data[0]=0xDEAD in the same cycle, and 0xDEAD with wr_en low the next cycle;
  - a write of 0x1234 to reg 0 → subsequent reads of reg 0 return 0.
- Scoreboard:
  - alloc reg 7 → next cycle rs_pending=1 for a port reading 7;
  - a write to 7 in a later cycle → pending=0 in that cycle through the bypass qualifier, and it stays 0;
  - alloc_en and wr_en to 7 in the same cycle → pending stays 1.
- Reset mid-operation:
  - write 0xFF to reg 3 and allocate reg 9 in RUN, then assert reset;
  - after the sweep with INIT_MODE=0, reg 3 reads 0 and reg 9 is not pending;
  - writes issued during INIT are discarded.
- Multi-port with NREAD=4: all four ports read distinct addresses, then all read the same address → every port returns the correct, matching data.
